// File: rtl/maxpool2d_relu_pkg.sv
// Shared definitions for the pooling layers: default word format, state codes
// and the flattened-frame indexing helper.
package maxpool2d_relu_pkg;

    localparam int DEF_N = 24;
    localparam int DEF_Q = 13;

    typedef logic signed [DEF_N-1:0] word_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POOL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit offset of element (row,col) in a row-major flattened frame.
    function automatic int elemOffset(input int row, input int col,
                                      input int width, input int n);
        return (row * width + col) * n;
    endfunction

endpackage

// File: rtl/maxpool2d_relu_cmp4.sv
// Combinational signed maximum of four words, with optional fused ReLU when
// MAXPOOL_RELU_EN is defined.
module maxpool_cmp4 #(
    parameter int N = 24
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] y
);

    logic signed [N-1:0] maxAb;
    logic signed [N-1:0] maxCd;
    logic signed [N-1:0] maxAll;

    assign maxAb  = (a > b) ? a : b;
    assign maxCd  = (c > d) ? c : d;
    assign maxAll = (maxAb > maxCd) ? maxAb : maxCd;

`ifdef MAXPOOL_RELU_EN
    assign y = maxAll[N-1] ? '0 : maxAll;
`else
    assign y = maxAll;
`endif

endmodule

// File: rtl/maxpool2d_relu.sv
// 2x2/stride-2 max pooling over one buffered frame, one output pixel per cycle;
// ReLU is fused in when MAXPOOL_RELU_EN is defined.
module maxpool2d_relu
    import maxpool2d_relu_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q,
    parameter int W = 6,
    parameter int H = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*W*H-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*(W/2)*(H/2)-1:0]     out_data,
    output logic                         busy
);

    localparam int P  = (W / 2) * (H / 2);
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    if (W < 2 || H < 2 || (W % 2) != 0 || (H % 2) != 0 || Q >= N) begin : g_paramCheck
        $error("maxpool2d_relu: W and H must be even and >= 2, and Q < N");
    end

    logic [1:0]          state;
    logic [N*W*H-1:0]    frameBuf;
    logic [IW-1:0]       idx;
    logic [N*P-1:0]      outData;

    int                  winRow;
    int                  winCol;
    logic signed [N-1:0] win00;
    logic signed [N-1:0] win01;
    logic signed [N-1:0] win10;
    logic signed [N-1:0] win11;
    logic signed [N-1:0] poolResult;

    // NOTE: combinational block uses blocking assignments, and every variable
    // is given a value on every pass so no latch is inferred.
    always_comb begin
        winRow = int'(idx) / (W / 2);
        winCol = int'(idx) % (W / 2);
        win00  = frameBuf[elemOffset(2*winRow,     2*winCol,     W, N) +: N];
        win01  = frameBuf[elemOffset(2*winRow,     2*winCol + 1, W, N) +: N];
        win10  = frameBuf[elemOffset(2*winRow + 1, 2*winCol,     W, N) +: N];
        win11  = frameBuf[elemOffset(2*winRow + 1, 2*winCol + 1, W, N) +: N];
    end

    maxpool_cmp4 #(.N(N)) u_cmp4 (
        .a (win00),
        .b (win01),
        .c (win10),
        .d (win11),
        .y (poolResult)
    );

    // NOTE: sequential state uses non-blocking assignments only. The frame
    // buffer and output register are reset as well, so an aborted frame leaves
    // nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frameBuf <= '0;
            idx      <= '0;
            outData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frameBuf <= in_data;
                        idx      <= '0;
                        state    <= POOL;
                    end
                end
                POOL: begin
                    outData[int'(idx)*N +: N] <= poolResult;
                    if (idx == IW'(P - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == POOL);
    assign out_valid = (state == DONE);
    assign out_data  = outData;

endmodule

// File: tb/tb_maxpool2d_relu.sv
// Randomized self-checking bench for maxpool2d_relu against an array-based
// max-pool reference; follows MAXPOOL_RELU_EN the same way the design does.
module tb_maxpool2d_relu;
    import maxpool2d_relu_pkg::*;

    localparam int N  = DEF_N;
    localparam int W  = 6;
    localparam int H  = 6;
    localparam int P  = (W / 2) * (H / 2);
    localparam int FB = N * W * H;
    localparam int OB = N * P;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FB-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OB-1:0] out_data;
    logic          busy;

    int nVec = 0;
    int nErr = 0;
    int cycle = 0;

    maxpool2d_relu #(.N(N), .Q(DEF_Q), .W(W), .H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got still running, want finished");
        $fatal(1, "simulation time limit");
    end

    task automatic checkVal(input string tag, input logic [OB-1:0] got, input logic [OB-1:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t reluOpt(input word_t v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? word_t'(0) : v;
`else
        return v;
`endif
    endfunction

    // Reference: unpack into a 2-D image, take the max of each 2x2 block.
    function automatic logic [OB-1:0] golden(input logic [FB-1:0] f);
        word_t px[H][W];
        word_t m;
        logic [OB-1:0] o;
        o = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                px[r][c] = f[(r*W + c)*N +: N];
        for (int pr = 0; pr < H/2; pr++)
            for (int pc = 0; pc < W/2; pc++) begin
                m = px[2*pr][2*pc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (px[2*pr+dr][2*pc+dc] > m) m = px[2*pr+dr][2*pc+dc];
                o[(pr*(W/2) + pc)*N +: N] = reluOpt(m);
            end
        return o;
    endfunction

    function automatic logic [FB-1:0] randFrame();
        logic [FB-1:0] f;
        for (int k = 0; k < W*H; k++) f[k*N +: N] = N'($urandom());
        return f;
    endfunction

    function automatic logic [FB-1:0] rampFrame();
        logic [FB-1:0] f;
        for (int k = 0; k < W*H; k++) f[k*N +: N] = N'(k * 8192);
        return f;
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        checkVal("in_ready_seen", OB'(in_ready), OB'(1));
    endtask

    task automatic waitOutValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        checkVal("out_valid_seen", OB'(out_valid), OB'(1));
    endtask

    // Accept a frame, check latency and result, then drain with one out_ready pulse.
    task automatic runFrame(input string tag, input logic [FB-1:0] f, input logic [OB-1:0] exp);
        int lat;
        waitReady();
        in_data  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = randFrame();
        checkVal({tag, "_busy"}, OB'(busy), OB'(1));
        waitOutValid(lat);
        checkVal({tag, "_latency"}, OB'(lat), OB'(P));
        checkVal({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkVal({tag, "_valid_pulse"}, OB'(out_valid), OB'(0));
    endtask

    logic [OB-1:0] rampExp;
    logic [OB-1:0] negExp;
    logic [FB-1:0] fA;
    logic [FB-1:0] fB;
    logic [FB-1:0] fMix;
    logic [OB-1:0] held;
    int            rampIdx[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int            lat;
    int            seen;
    int            lastAccept;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick(); tick();
        checkVal("reset_in_ready", OB'(in_ready), OB'(1));
        checkVal("reset_out_valid", OB'(out_valid), OB'(0));
        checkVal("reset_busy", OB'(busy), OB'(0));
        checkVal("reset_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        for (int s = 0; s < P; s++) rampExp[s*N +: N] = N'(rampIdx[s] * 8192);
        runFrame("ramp", rampFrame(), rampExp);

        // Reset mid-idle must also clear the previous frame's results.
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checkVal("idle_reset_out_data", out_data, '0);
        checkVal("idle_reset_in_ready", OB'(in_ready), OB'(1));

        fA = '0;
        for (int k = 0; k < W*H; k++) fA[k*N +: N] = 24'hFFE000;
`ifdef MAXPOOL_RELU_EN
        negExp = '0;
`else
        for (int s = 0; s < P; s++) negExp[s*N +: N] = 24'hFFE000;
`endif
        runFrame("neg", fA, negExp);

        fMix = randFrame();
        fMix[(0*W + 0)*N +: N] = -24'sd5;
        fMix[(0*W + 1)*N +: N] = -24'sd3;
        fMix[(1*W + 0)*N +: N] = -24'sd8192;
        fMix[(1*W + 1)*N +: N] = -24'sd1;
        runFrame("mixed", fMix, golden(fMix));
`ifdef MAXPOOL_RELU_EN
        checkVal("mixed_slot0", OB'(out_data[N-1:0]), OB'(0));
`else
        checkVal("mixed_slot0", OB'(out_data[N-1:0]), OB'(24'hFFFFFF));
`endif

        for (int i = 0; i < 4; i++) begin
            fA = randFrame();
            runFrame("random", fA, golden(fA));
        end

        // Backpressure: result held while out_ready is low; a pending frame waits.
        fA = randFrame();
        fB = randFrame();
        waitReady();
        in_data  = fA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitOutValid(lat);
        held     = out_data;
        checkVal("bp_data", held, golden(fA));
        in_data  = fB;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("bp_valid_hold", OB'(out_valid), OB'(1));
            checkVal("bp_data_hold", out_data, held);
            checkVal("bp_in_ready", OB'(in_ready), OB'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkVal("bp_release_valid", OB'(out_valid), OB'(0));
        checkVal("bp_release_not_busy", OB'(busy), OB'(0));
        checkVal("bp_release_in_ready", OB'(in_ready), OB'(1));
        tick();
        in_valid = 1'b0;
        checkVal("bp_second_accepted", OB'(busy), OB'(1));
        waitOutValid(lat);
        checkVal("bp_second_latency", OB'(lat), OB'(P));
        checkVal("bp_second_data", out_data, golden(fB));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset on the 4th POOL cycle aborts the frame silently.
        waitReady();
        in_data  = randFrame();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checkVal("abort_still_busy", OB'(busy), OB'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("abort_idle_busy", OB'(busy), OB'(0));
        checkVal("abort_idle_in_ready", OB'(in_ready), OB'(1));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checkVal("abort_no_valid", OB'(seen), OB'(0));
        runFrame("ramp_after_abort", rampFrame(), rampExp);

        // Back-to-back: in_valid and out_ready held high, distinct frames.
        out_ready  = 1'b1;
        lastAccept = 0;
        for (int i = 0; i < 5; i++) begin
            fA       = randFrame();
            in_data  = fA;
            in_valid = 1'b1;
            waitReady();
            tick();
            in_data = randFrame();
            if (i > 0) checkVal("b2b_period", OB'(cycle - lastAccept), OB'(P + 2));
            lastAccept = cycle;
            waitOutValid(lat);
            checkVal("b2b_latency", OB'(lat), OB'(P));
            checkVal("b2b_data", out_data, golden(fA));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
